rv32imf_prefetch_buffer: RTL and testbench
==========================================

RV32IMF_PREFETCH_BUFFER -- requirements
Module: rv32imf_prefetch_buffer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, word entries buffered toward the aligner (power of two, >=2).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, maximum granted-but-unanswered memory requests.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_i  input  1  fetch enable; new memory requests only while high.
REQ-006 SHALL have port branch_i  input  1  one-cycle redirect pulse.
REQ-007 SHALL have port branch_addr_i  input  32  redirect target (byte address, halfword aligned).
REQ-008 SHALL have port fetch_valid_o  output  1  word available to aligner.
REQ-009 SHALL have port fetch_ready_i  input  1  aligner accepts word (pop when valid&ready).
REQ-010 SHALL have port fetch_rdata_o  output  32  fetched instruction word.
REQ-011 SHALL have port instr_req_o  output  1  memory request.
REQ-012 SHALL have port instr_gnt_i  input  1  memory grant.
REQ-013 SHALL have port instr_addr_o  output  32  word-aligned request address.
REQ-014 SHALL have port instr_rvalid_i  input  1  response valid, in request order.
REQ-015 SHALL have port instr_rdata_i  input  32  response data.
REQ-016 SHALL have port busy_o  output  1  outstanding requests nonzero or FIFO nonempty.

Function
REQ-017 SHALL run FSM IDLE (no request), REQ (instr_req_o=1, awaiting gnt), WAIT_GNT_FLUSH (redirect pending behind ungranted request).
REQ-018 SHALL issue a request only when req_i=1 and outstanding+FIFO count < FIFO_DEPTH and outstanding < MAX_OUTSTANDING.
REQ-019 SHALL hold instr_req_o and instr_addr_o stable from assertion until instr_gnt_i=1.
REQ-020 SHALL advance the fetch address by 4 on each grant; address bits [1:0] always 00.
REQ-021 SHALL push each non-discarded response into the FIFO; push and pop in the same cycle on a full FIFO SHALL be legal and keep count unchanged.
REQ-022 SHALL present FIFO head on fetch_rdata_o; fetch_valid_o=1 iff FIFO nonempty (or bypass, REQ-030).
REQ-023 On branch_i SHALL flush the FIFO same cycle, set next address to {branch_addr_i[31:2],2'b00}, and load a discard counter with the current outstanding count (including a request granted that cycle).
REQ-024 SHALL drop responses while discard counter > 0, decrementing once per instr_rvalid_i.
REQ-025 Branch while in REQ without grant SHALL enter WAIT_GNT_FLUSH, keep old address until granted, count that response as discarded, then request the branch target.
REQ-026 fetch_valid_o SHALL be 0 in the branch cycle; branch has priority over a simultaneous pop.
REQ-027 SHALL keep outstanding and discard counters saturating-safe: never underflow, never exceed MAX_OUTSTANDING.
REQ-028 req_i falling SHALL stop new requests but still collect outstanding responses.

Reset
REQ-029 While rst_n=0 SHALL force: state IDLE, instr_req_o=0, instr_addr_o=0, fetch_valid_o=0, fetch_rdata_o=0, busy_o=0, counters 0, FIFO empty; first request after reset only after branch_i supplies an address.

Configuration
REQ-030 With RV32IMF_FETCH_BYPASS_EN defined SHALL forward instr_rdata_i directly to the aligner when FIFO empty and response not discarded (zero-latency; pushed only if not popped); without it all data SHALL pass through the FIFO (one extra cycle).

Structure
REQ-031 SHALL place the FSM state enum and default depth constants in rv32imf_pkg.
REQ-032 SHALL instantiate sub-module rv32imf_fetch_fifo (push/pop/flush/count) for storage.

Verification
REQ-033 Branch to 0x0000_0100, gnt/rvalid each next cycle, ready=1 -> addresses 0x100,0x104,0x108, data delivered in order.
REQ-034 fetch_ready_i=0 with FIFO_DEPTH=2 -> exactly 2 requests issued, instr_req_o then 0 until a pop.
REQ-035 Branch to 0x0000_0202 with 2 outstanding -> both old responses dropped, next request address 0x200, first delivered word is its data.
REQ-036 Branch during unanswered req at 0x40 (gnt=0 three cycles) -> addr stays 0x40 until gnt, then target issued, 0x40 data discarded.
REQ-037 Full FIFO, simultaneous push and pop -> count stays 2, order preserved.
REQ-038 rst_n asserted mid-burst -> all outputs 0 immediately, late rvalid ignored after release.

Source files
------------

// File: rtl/rv32imf_pkg.sv
// ============================================================================
// rv32imf_pkg : shared prefetch FSM state encoding and default depth constants
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rv32imf_pkg;

    typedef enum logic [1:0] {
        PF_IDLE           = 2'd0,
        PF_REQ            = 2'd1,
        PF_WAIT_GNT_FLUSH = 2'd2
    } pf_state_e;

    localparam int unsigned PF_FIFO_DEPTH_DEFAULT      = 2;
    localparam int unsigned PF_MAX_OUTSTANDING_DEFAULT = 2;

endpackage

`default_nettype wire

// File: rtl/rv32imf_fetch_fifo.sv
// ============================================================================
// rv32imf_fetch_fifo : instruction word FIFO with push/pop/flush and count
// Revision           : 1.0
// ============================================================================
`default_nettype none

module rv32imf_fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W-1:0] wptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok;
    logic             push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

`default_nettype wire

// File: rtl/rv32imf_prefetch_buffer.sv
// ============================================================================
// rv32imf_prefetch_buffer : instruction prefetcher with redirect/discard logic
// Option : RV32IMF_FETCH_BYPASS_EN forwards responses straight to the aligner
// Revision : 1.0
// ============================================================================
`default_nettype none

module rv32imf_prefetch_buffer
    import rv32imf_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = PF_FIFO_DEPTH_DEFAULT,
    parameter int unsigned MAX_OUTSTANDING = PF_MAX_OUTSTANDING_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic [31:0] fetch_rdata_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        busy_o
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    pf_state_e        state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      target_q, target_d;
    logic             addr_valid_q, addr_valid_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [OUT_W-1:0] discard_q, discard_d;

    logic [31:0]      branch_target;
    logic             can_issue;
    logic             granted;
    logic             accept;
    logic             drop;
    logic             deliver;
    logic             fifo_push;
    logic             fifo_pop;
    logic [31:0]      fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             unused_addr_bits;

    assign branch_target    = {branch_addr_i[31:2], 2'b00};
    assign unused_addr_bits = ^{branch_addr_i[1:0], fifo_full};

    assign can_issue = req_i && addr_valid_q
                     && ((32'(outstanding_q) + 32'(fifo_count)) < FIFO_DEPTH)
                     && (32'(outstanding_q) < MAX_OUTSTANDING);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        target_d     = target_q;
        addr_valid_d = addr_valid_q;
        instr_req_o  = 1'b0;

        unique case (state_q)
            PF_IDLE: begin
                // The old address is stale during a redirect, so hold off one cycle.
                instr_req_o = can_issue && !branch_i;
                if (instr_req_o && !instr_gnt_i) begin
                    state_d = PF_REQ;
                end
            end
            PF_REQ: begin
                instr_req_o = 1'b1;
                if (instr_gnt_i) begin
                    state_d = PF_IDLE;
                end else if (branch_i) begin
                    state_d = PF_WAIT_GNT_FLUSH;
                end
            end
            PF_WAIT_GNT_FLUSH: begin
                instr_req_o = 1'b1;
                if (instr_gnt_i) begin
                    state_d = PF_IDLE;
                end
            end
            default: state_d = PF_IDLE;
        endcase

        granted = instr_req_o && instr_gnt_i;

        if (branch_i) begin
            target_d     = branch_target;
            addr_valid_d = 1'b1;
            // An ungranted request must keep its address; the target waits in target_q.
            if (!(instr_req_o && !instr_gnt_i)) begin
                addr_d = branch_target;
            end
        end else if (granted) begin
            addr_d = (state_q == PF_WAIT_GNT_FLUSH) ? target_q : (addr_q + 32'd4);
        end
    end

    // Responses with nothing outstanding (e.g. from before a reset) are ignored.
    assign accept  = instr_rvalid_i && (outstanding_q != '0);
    assign drop    = accept && (discard_q != '0);
    assign deliver = accept && !drop && !branch_i;

    always_comb begin
        outstanding_d = outstanding_q + OUT_W'(granted) - OUT_W'(accept);
        if (branch_i) begin
            discard_d = outstanding_d;
        end else begin
            discard_d = discard_q - OUT_W'(drop)
                      + OUT_W'(granted && (state_q == PF_WAIT_GNT_FLUSH));
        end
    end

`ifdef RV32IMF_FETCH_BYPASS_EN
    logic bypass;
    assign bypass        = deliver && fifo_empty;
    assign fetch_valid_o = !branch_i && (!fifo_empty || bypass);
    assign fetch_rdata_o = bypass ? instr_rdata_i : fifo_head;
    assign fifo_pop      = fetch_valid_o && fetch_ready_i && !fifo_empty;
    assign fifo_push     = deliver && !(bypass && fetch_ready_i);
`else
    assign fetch_valid_o = !branch_i && !fifo_empty;
    assign fetch_rdata_o = fifo_head;
    assign fifo_pop      = fetch_valid_o && fetch_ready_i;
    assign fifo_push     = deliver;
`endif

    assign instr_addr_o = addr_q;
    assign busy_o       = (outstanding_q != '0) || !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= PF_IDLE;
            addr_q        <= '0;
            target_q      <= '0;
            addr_valid_q  <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            target_q      <= target_d;
            addr_valid_q  <= addr_valid_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    rv32imf_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (branch_i),
        .push_i  (fifo_push),
        .wdata_i (instr_rdata_i),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

endmodule

`default_nettype wire

// File: tb/tb_rv32imf_prefetch_buffer.sv
// ============================================================================
// tb_rv32imf_prefetch_buffer : directed self-checking bench for the prefetcher
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rv32imf_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        fetch_valid_o;
    logic        fetch_ready_i = 1'b0;
    logic [31:0] fetch_rdata_o;
    logic        instr_req_o;
    logic        instr_gnt_i = 1'b0;
    logic [31:0] instr_addr_o;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        busy_o;

    logic        f_push = 1'b0;
    logic        f_pop = 1'b0;
    logic [31:0] f_wdata = '0;
    logic [31:0] f_rdata;
    logic [1:0]  f_count;
    logic        f_empty;
    logic        f_full;

    int checks = 0;
    int errors = 0;

    logic [31:0] issued[$];
    logic [31:0] got[$];
    logic [31:0] pq[$];

    always #5 clk = ~clk;

    rv32imf_prefetch_buffer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .fetch_valid_o  (fetch_valid_o),
        .fetch_ready_i  (fetch_ready_i),
        .fetch_rdata_o  (fetch_rdata_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .busy_o         (busy_o)
    );

    rv32imf_fetch_fifo #(.DEPTH(2), .WIDTH(32)) u_fifo_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (1'b0),
        .push_i  (f_push),
        .wdata_i (f_wdata),
        .pop_i   (f_pop),
        .rdata_o (f_rdata),
        .count_o (f_count),
        .empty_o (f_empty),
        .full_o  (f_full)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    // Memory model: grant when enabled, answer in order at least one cycle later.
    task automatic mem_cycles(input int n, input bit gnt_on, input bit rv_on,
                              input bit br, input logic [31:0] br_addr);
        for (int i = 0; i < n; i++) begin
            branch_i       = br && (i == 0);
            branch_addr_i  = br_addr;
            instr_gnt_i    = gnt_on;
            instr_rvalid_i = rv_on && (pq.size() != 0);
            instr_rdata_i  = instr_rvalid_i ? mdata(pq[0]) : 32'h0;
            #1;
            if (instr_rvalid_i) void'(pq.pop_front());
            if (instr_req_o && instr_gnt_i) begin
                issued.push_back(instr_addr_o);
                pq.push_back(instr_addr_o);
            end
            if (fetch_valid_o && fetch_ready_i) got.push_back(fetch_rdata_o);
            @(posedge clk); #1;
        end
        branch_i = 1'b0;
    endtask

    task automatic drain();
        req_i         = 1'b0;
        fetch_ready_i = 1'b1;
        for (int i = 0; i < 30 && (busy_o || instr_req_o || pq.size() != 0); i++)
            mem_cycles(1, 1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (busy_o !== 1'b0 || pq.size() != 0) begin
            errors++;
            $display("FAIL drain: busy_o=%b pending=%0d, required busy_o=0 pending=0", busy_o, pq.size());
        end
    endtask

    task automatic test_reset();
        req_i = 1'b1; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (instr_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", instr_req_o); end
        if (instr_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h required 0", instr_addr_o); end
        if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", fetch_valid_o); end
        if (fetch_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h required 0", fetch_rdata_o); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy_o); end
        instr_rvalid_i = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (instr_req_o !== 1'b0) begin errors++; $display("FAIL no_req_before_branch: got %b required 0", instr_req_o); end
    endtask

    task automatic test_in_order();
        issued.delete(); got.delete();
        req_i = 1'b1; fetch_ready_i = 1'b1;
        mem_cycles(1, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
        mem_cycles(9, 1'b1, 1'b1, 1'b0, 32'h0);
        drain();
        checks += 7;
        if (issued.size() < 3) begin errors++; $display("FAIL seq_count: got %0d required >=3", issued.size()); end
        if (issued[0] !== 32'h100) begin errors++; $display("FAIL seq_addr0: got %h required 00000100", issued[0]); end
        if (issued[1] !== 32'h104) begin errors++; $display("FAIL seq_addr1: got %h required 00000104", issued[1]); end
        if (issued[2] !== 32'h108) begin errors++; $display("FAIL seq_addr2: got %h required 00000108", issued[2]); end
        if (got[0] !== mdata(32'h100)) begin errors++; $display("FAIL seq_data0: got %h required %h", got[0], mdata(32'h100)); end
        if (got[2] !== mdata(32'h108)) begin errors++; $display("FAIL seq_data2: got %h required %h", got[2], mdata(32'h108)); end
        if (got.size() != issued.size()) begin errors++; $display("FAIL seq_drain: delivered %0d required %0d", got.size(), issued.size()); end
    endtask

    task automatic test_backpressure();
        issued.delete(); got.delete();
        req_i = 1'b1; fetch_ready_i = 1'b0;
        mem_cycles(1, 1'b1, 1'b1, 1'b1, 32'h0000_0300);
        mem_cycles(6, 1'b1, 1'b1, 1'b0, 32'h0);
        checks += 5;
        if (issued.size() != 2) begin errors++; $display("FAIL bp_count: got %0d required 2", issued.size()); end
        if (issued[1] !== 32'h304) begin errors++; $display("FAIL bp_addr1: got %h required 00000304", issued[1]); end
        if (instr_req_o !== 1'b0) begin errors++; $display("FAIL bp_req_low: got %b required 0", instr_req_o); end
        if (fetch_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b required 1", fetch_valid_o); end
        if (fetch_rdata_o !== mdata(32'h300)) begin errors++; $display("FAIL bp_head: got %h required %h", fetch_rdata_o, mdata(32'h300)); end
        fetch_ready_i = 1'b1;
        mem_cycles(1, 1'b1, 1'b1, 1'b0, 32'h0);
        checks += 2;
        if (instr_req_o !== 1'b1) begin errors++; $display("FAIL bp_resume_req: got %b required 1", instr_req_o); end
        if (instr_addr_o !== 32'h308) begin errors++; $display("FAIL bp_resume_addr: got %h required 00000308", instr_addr_o); end
        // Redirect while a word is waiting: branch wins over the pop.
        branch_i = 1'b1; branch_addr_i = 32'h0000_0600; instr_gnt_i = 1'b0; #1;
        checks += 2;
        if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL br_cycle_valid: got %b required 0", fetch_valid_o); end
        if (instr_req_o !== 1'b0) begin errors++; $display("FAIL br_cycle_req: got %b required 0", instr_req_o); end
        @(posedge clk); #1;
        branch_i = 1'b0; #1;
        checks += 3;
        if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL br_flushed: got %b required 0", fetch_valid_o); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL br_busy: got %b required 0", busy_o); end
        if (instr_addr_o !== 32'h600) begin errors++; $display("FAIL br_target: got %h required 00000600", instr_addr_o); end
        issued.delete(); got.delete();
        mem_cycles(4, 1'b1, 1'b1, 1'b0, 32'h0);
        drain();
        checks++;
        if (got[0] !== mdata(32'h600)) begin errors++; $display("FAIL br_first_data: got %h required %h", got[0], mdata(32'h600)); end
    endtask

    task automatic test_branch_outstanding();
        issued.delete(); got.delete();
        req_i = 1'b1; fetch_ready_i = 1'b1;
        mem_cycles(1, 1'b1, 1'b0, 1'b1, 32'h0000_0500);
        mem_cycles(2, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (pq.size() != 2) begin errors++; $display("FAIL disc_outstanding: got %0d required 2", pq.size()); end
        issued.delete();
        mem_cycles(1, 1'b1, 1'b1, 1'b1, 32'h0000_0202);
        mem_cycles(6, 1'b1, 1'b1, 1'b0, 32'h0);
        drain();
        checks += 3;
        if (issued[0] !== 32'h200) begin errors++; $display("FAIL disc_addr: got %h required 00000200", issued[0]); end
        if (got[0] !== mdata(32'h200)) begin errors++; $display("FAIL disc_first: got %h required %h", got[0], mdata(32'h200)); end
        if (got.size() != issued.size()) begin errors++; $display("FAIL disc_count: delivered %0d required %0d", got.size(), issued.size()); end
    endtask

    task automatic test_wait_gnt_flush();
        issued.delete(); got.delete();
        req_i = 1'b1; fetch_ready_i = 1'b1;
        mem_cycles(1, 1'b0, 1'b1, 1'b1, 32'h0000_0040);
        mem_cycles(1, 1'b0, 1'b1, 1'b0, 32'h0);
        branch_i = 1'b1; branch_addr_i = 32'h0000_0080; instr_gnt_i = 1'b0; #1;
        checks += 2;
        if (instr_req_o !== 1'b1) begin errors++; $display("FAIL wgf_req_held: got %b required 1", instr_req_o); end
        if (instr_addr_o !== 32'h40) begin errors++; $display("FAIL wgf_addr_held: got %h required 00000040", instr_addr_o); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            branch_i = 1'b0; #1;
            checks++;
            if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h40) begin
                errors++;
                $display("FAIL wgf_wait%0d: req %b addr %h required 1 00000040", i, instr_req_o, instr_addr_o);
            end
        end
        mem_cycles(6, 1'b1, 1'b1, 1'b0, 32'h0);
        drain();
        checks += 4;
        if (issued[0] !== 32'h40) begin errors++; $display("FAIL wgf_first_addr: got %h required 00000040", issued[0]); end
        if (issued[1] !== 32'h80) begin errors++; $display("FAIL wgf_target_addr: got %h required 00000080", issued[1]); end
        if (got[0] !== mdata(32'h80)) begin errors++; $display("FAIL wgf_first_data: got %h required %h", got[0], mdata(32'h80)); end
        if (got.size() + 1 != issued.size()) begin errors++; $display("FAIL wgf_count: delivered %0d required %0d", got.size(), issued.size() - 1); end
    endtask

    task automatic test_fifo_full();
        f_push = 1'b1; f_wdata = 32'hAAAA_0001;
        @(posedge clk); #1;
        f_wdata = 32'hBBBB_0002;
        @(posedge clk); #1;
        f_push = 1'b0; #1;
        checks += 3;
        if (f_count !== 2'd2) begin errors++; $display("FAIL ff_count_full: got %0d required 2", f_count); end
        if (f_full !== 1'b1) begin errors++; $display("FAIL ff_full: got %b required 1", f_full); end
        if (f_rdata !== 32'hAAAA_0001) begin errors++; $display("FAIL ff_head0: got %h required aaaa0001", f_rdata); end
        f_push = 1'b1; f_pop = 1'b1; f_wdata = 32'hCCCC_0003;
        @(posedge clk); #1;
        f_push = 1'b0; f_pop = 1'b0; #1;
        checks += 2;
        if (f_count !== 2'd2) begin errors++; $display("FAIL ff_count_pushpop: got %0d required 2", f_count); end
        if (f_rdata !== 32'hBBBB_0002) begin errors++; $display("FAIL ff_head1: got %h required bbbb0002", f_rdata); end
        f_pop = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (f_rdata !== 32'hCCCC_0003) begin errors++; $display("FAIL ff_head2: got %h required cccc0003", f_rdata); end
        @(posedge clk); #1;
        f_pop = 1'b0; #1;
        checks++;
        if (f_empty !== 1'b1) begin errors++; $display("FAIL ff_empty: got %b required 1", f_empty); end
    endtask

    task automatic test_reset_midburst();
        issued.delete(); got.delete();
        req_i = 1'b1; fetch_ready_i = 1'b1;
        mem_cycles(1, 1'b1, 1'b0, 1'b1, 32'h0000_0700);
        mem_cycles(2, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b required 1", busy_o); end
        rst_n = 1'b0; #1;
        checks += 4;
        if (instr_req_o !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got %b required 0", instr_req_o); end
        if (instr_addr_o !== 32'h0) begin errors++; $display("FAIL mid_rst_addr: got %h required 0", instr_addr_o); end
        if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b required 0", fetch_valid_o); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b required 0", busy_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        pq.delete();
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'hDEAD_BEEF; instr_gnt_i = 1'b1; #1;
        checks++;
        if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL late_rvalid_bypass: got %b required 0", fetch_valid_o); end
        @(posedge clk); #1;
        instr_rvalid_i = 1'b0; #1;
        checks += 3;
        if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL late_rvalid_valid: got %b required 0", fetch_valid_o); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL late_rvalid_busy: got %b required 0", busy_o); end
        if (instr_req_o !== 1'b0) begin errors++; $display("FAIL post_rst_req: got %b required 0", instr_req_o); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_backpressure();
        test_branch_outstanding();
        test_wait_gnt_flush();
        test_fifo_full();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
